// File: rtl/vx_exec_lane_splitter.sv
// vx_exec_lane_splitter: emits a captured full-warp instruction as NUM_LANES-wide packets, skipping empty slices
module vx_exec_lane_splitter #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int META_W      = 64,
  parameter int NT_W        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  parameter int PID_W       = (NUM_THREADS / NUM_LANES > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [META_W-1:0]             in_meta,
  input  logic [NUM_THREADS-1:0]        in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0]   in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0]   in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0]   in_rs3_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [META_W-1:0]             out_meta,
  output logic [NUM_LANES-1:0]          out_tmask,
  output logic [NT_W-1:0]               out_tid,
  output logic [NUM_LANES*XLEN-1:0]     out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]     out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]     out_rs3_data,
  output logic [PID_W-1:0]              out_pid,
  output logic                          out_sop,
  output logic                          out_eop
);
  localparam int NP = NUM_THREADS / NUM_LANES;
  localparam int SW = NUM_LANES * XLEN;
  typedef enum logic {IDLE, SEND} state_t;
  state_t                      r_state;
  logic [META_W-1:0]           r_meta;
  logic [NUM_THREADS-1:0]      r_tmask;
  logic [NUM_THREADS*XLEN-1:0] r_rs1, r_rs2, r_rs3;
  logic [NT_W-1:0]             r_tid;
  logic [PID_W-1:0]            r_pid;
  logic                        r_valid, r_sop, r_eop;
  logic [NP-1:0]               w_in_nz, w_r_nz;
  logic [PID_W-1:0]            w_in_first, w_nx;
  logic                        w_in_eop, w_nx_eop, w_accept, w_fire;
  logic [NT_W-1:0]             w_in_tid;
  // Descending scans leave the lowest qualifying index; eop means no nonzero slice above the chosen one.
  always_comb begin
    w_in_nz    = '0;
    w_r_nz     = '0;
    w_in_first = '0;
    w_nx       = r_pid;
    w_in_eop   = 1'b1;
    w_nx_eop   = 1'b1;
    w_in_tid   = '0;
    for (int k = 0; k < NP; k++) begin
      w_in_nz[k] = |in_tmask[k*NUM_LANES +: NUM_LANES];
      w_r_nz[k]  = |r_tmask[k*NUM_LANES +: NUM_LANES];
    end
    for (int k = NP - 1; k >= 0; k--) begin
      if (w_in_nz[k]) w_in_first = PID_W'(k);
      if (w_r_nz[k] && k > int'(r_pid)) w_nx = PID_W'(k);
    end
    for (int k = 0; k < NP; k++) begin
      if (w_in_nz[k] && k > int'(w_in_first)) w_in_eop = 1'b0;
      if (w_r_nz[k] && k > int'(w_nx)) w_nx_eop = 1'b0;
    end
    for (int t = NUM_THREADS - 1; t >= 0; t--)
      if (in_tmask[t]) w_in_tid = NT_W'(t);
  end
  assign in_ready = (r_state == IDLE) || (r_state == SEND && out_ready && r_eop);
  assign w_accept = in_valid && in_ready;
  assign w_fire   = r_valid && out_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_meta  <= '0;
      r_tmask <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rs3   <= '0;
      r_tid   <= '0;
      r_pid   <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (w_accept) begin
      r_state <= |in_tmask ? SEND : IDLE;
      r_valid <= |in_tmask;
      r_meta  <= in_meta;
      r_tmask <= in_tmask;
      r_rs1   <= in_rs1_data;
      r_rs2   <= in_rs2_data;
      r_rs3   <= in_rs3_data;
      r_tid   <= w_in_tid;
      r_pid   <= w_in_first;
      r_sop   <= |in_tmask;
      r_eop   <= |in_tmask && w_in_eop;
    end else if (w_fire) begin
      r_state <= r_eop ? IDLE : SEND;
      r_valid <= !r_eop;
      r_pid   <= r_eop ? '0 : w_nx;
      r_sop   <= 1'b0;
      r_eop   <= !r_eop && w_nx_eop;
    end
  end
  assign out_valid    = r_valid;
  assign out_meta     = r_meta;
  assign out_tid      = r_tid;
  assign out_pid      = r_pid;
  assign out_sop      = r_sop;
  assign out_eop      = r_eop;
  assign out_tmask    = r_tmask[r_pid*NUM_LANES +: NUM_LANES];
  assign out_rs1_data = r_rs1[r_pid*SW +: SW];
  assign out_rs2_data = r_rs2[r_pid*SW +: SW];
  assign out_rs3_data = r_rs3[r_pid*SW +: SW];
endmodule

// File: tb/tb_vx_exec_lane_splitter.sv
// tb_vx_exec_lane_splitter: random and directed traffic checked against a packet-queue reference model
module tb_vx_exec_lane_splitter;
  localparam int NT = 4, NL = 2, XL = 32, MW = 64, NP = NT / NL;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_sop, out_eop;
  logic [MW-1:0] in_meta = '0, out_meta;
  logic [NT-1:0] in_tmask = '0;
  logic [NT*XL-1:0] in_rs1_data = '0, in_rs2_data = '0, in_rs3_data = '0;
  logic [NL-1:0] out_tmask;
  logic [1:0] out_tid;
  logic [NL*XL-1:0] out_rs1_data, out_rs2_data, out_rs3_data;
  logic [0:0] out_pid;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  vx_exec_lane_splitter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_meta(in_meta),
    .in_tmask(in_tmask), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs3_data(in_rs3_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_meta(out_meta), .out_tmask(out_tmask), .out_tid(out_tid),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data),
    .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop)
  );

  typedef struct {
    logic [MW-1:0]    meta;
    logic [NL-1:0]    tm;
    logic [1:0]       tid;
    logic [0:0]       pid;
    logic             sop, eop;
    logic [NL*XL-1:0] r1, r2, r3;
  } pkt_t;
  pkt_t q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected packet list for one accepted instruction: one entry per nonzero slice.
  task automatic model_push();
    int n = 0, seen = 0;
    logic [1:0] tid = '0;
    pkt_t p;
    for (int t = NT - 1; t >= 0; t--) if (in_tmask[t]) tid = 2'(t);
    for (int k = 0; k < NP; k++) if (in_tmask[k*NL +: NL] != 0) n++;
    for (int k = 0; k < NP; k++) begin
      if (in_tmask[k*NL +: NL] != 0) begin
        seen++;
        p.meta = in_meta;
        p.tm   = in_tmask[k*NL +: NL];
        p.tid  = tid;
        p.pid  = 1'(k);
        p.sop  = (seen == 1);
        p.eop  = (seen == n);
        p.r1   = in_rs1_data[k*NL*XL +: NL*XL];
        p.r2   = in_rs2_data[k*NL*XL +: NL*XL];
        p.r3   = in_rs3_data[k*NL*XL +: NL*XL];
        q.push_back(p);
      end
    end
  endtask

  task automatic step(input bit iv, input logic [NT-1:0] tm, input bit ordy);
    bit exp_ready;
    @(negedge clk);
    in_valid = iv;
    in_tmask = tm;
    in_meta  = {$urandom, $urandom};
    for (int l = 0; l < NT; l++) begin
      in_rs1_data[l*XL +: XL] = $urandom;
      in_rs2_data[l*XL +: XL] = $urandom;
      in_rs3_data[l*XL +: XL] = $urandom;
    end
    out_ready = ordy;
    #1;
    exp_ready = (q.size() == 0) || (ordy && q.size() == 1);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0 && out_valid) begin
      chk("meta", out_meta, q[0].meta);
      chk("tmask", out_tmask, q[0].tm);
      chk("tid", out_tid, q[0].tid);
      chk("pid", out_pid, q[0].pid);
      chk("sop", out_sop, q[0].sop);
      chk("eop", out_eop, q[0].eop);
      chk("rs1", out_rs1_data, q[0].r1);
      chk("rs2", out_rs2_data, q[0].r2);
      chk("rs3", out_rs3_data, q[0].r3);
    end
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (iv && exp_ready) model_push();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_pid", out_pid, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    reset = 1'b0;
    step(1, 4'b1111, 1); step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    step(1, 4'b1100, 1); step(0, 0, 1); step(0, 0, 1);
    step(1, 4'b0000, 1); step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    step(1, 4'b1111, 0);
    repeat (5) step(0, 0, 0);
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    step(1, 4'b1111, 1); step(1, 4'b0011, 1); step(1, 4'b0011, 1); step(0, 0, 1); step(0, 0, 1);
    step(1, 4'b1111, 1); step(1, 4'b0000, 1); step(1, 4'b0000, 1); step(0, 0, 1); step(0, 0, 1);
    step(1, 4'b1111, 0); step(0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 1);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    repeat (3000) step(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 3) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vx_exec_lane_splitter.md
Name: vx_exec_lane_splitter

Overview:
- Sits directly upstream of the execute interface, between operand collection and each functional unit.
- Accepts one full-warp instruction (NUM_THREADS lanes of operands) and emits it as one or more NUM_LANES-wide packets.
- Each packet carries pid/sop/eop framing; packets whose thread-mask slice is all zero are skipped.
- Per-instruction metadata is passed through unchanged on every packet.

Parameters:
- NUM_THREADS, 4, threads per warp; power of two.
- NUM_LANES, 2, lanes per output packet; power of two, divides NUM_THREADS.
- XLEN, 32, operand width.
- META_W, 64, packed passthrough metadata width (uuid, wid, PC, op_type, op_args, wb, rd, rrs_id).
- NT_W, LOG2UP(NUM_THREADS), tid width.
- PID_W, LOG2UP(NUM_THREADS/NUM_LANES), packet index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  input instruction valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_meta  in  META_W  passthrough metadata
- in_tmask  in  NUM_THREADS  full-warp thread mask
- in_rs1_data  in  NUM_THREADS*XLEN  operand 1, lane-major
- in_rs2_data  in  NUM_THREADS*XLEN  operand 2
- in_rs3_data  in  NUM_THREADS*XLEN  operand 3
- out_valid  out  1  packet valid
- out_ready  in  1  packet consumed when out_valid && out_ready
- out_meta  out  META_W  copy of captured in_meta
- out_tmask  out  NUM_LANES  tmask slice for pid
- out_tid  out  NT_W  index of lowest set bit of full captured tmask
- out_rs1_data  out  NUM_LANES*XLEN  slice pid of rs1
- out_rs2_data  out  NUM_LANES*XLEN  slice pid of rs2
- out_rs3_data  out  NUM_LANES*XLEN  slice pid of rs3
- out_pid  out  PID_W  packet index
- out_sop  out  1  first emitted packet of the instruction
- out_eop  out  1  last emitted packet of the instruction

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - out_valid=0, out_pid=0, out_sop=0, out_eop=0, holding register cleared, in_ready=1.
- Slicing: slice k is lanes [k*NUM_LANES, (k+1)*NUM_LANES).
- NUM_PACKETS = NUM_THREADS/NUM_LANES.
- If NUM_PACKETS==1: out_pid=0, sop=eop=1, and the block behaves as a one-deep pipeline register.
- FSM IDLE / SEND:
  - IDLE: in_ready=1. On accept with nonzero in_tmask:
    - capture meta, tmask and operands.
    - pid := lowest k whose slice is nonzero; sop:=1.
    - eop := no higher nonzero slice.
    - go to SEND with out_valid=1 on the next cycle (latency 1 cycle).
  - IDLE, accept with in_tmask==0: instruction consumed and dropped; no packet; stay IDLE.
  - SEND: outputs stable while out_valid && !out_ready.
    - On handshake with !eop: pid := next higher nonzero slice; sop:=0; eop recomputed.
    - On handshake with eop: return to IDLE, or reload directly (see below).
- in_ready = IDLE || (SEND && out_ready && out_eop).
  - Back-to-back instructions therefore have zero bubble cycles.
- Simultaneous last-packet handshake and input accept:
  - New instruction captured; out_valid stays 1 with the new first packet next cycle.
  - If the new tmask is zero, go to IDLE with out_valid=0.
- out_tid is computed once at capture and held for all packets of that instruction.
- No combinational path from in_* to out_*.
- The only combinational path from out_ready is to in_ready.
- Reset mid-instruction: remaining packets are discarded; no partial output after reset deasserts.

Test Plan:
- NUM_THREADS=4, NUM_LANES=2, tmask=4'b1111, rs1 lanes={4,3,2,1}, out_ready=1 -> cycle+1: pid0 tmask=11 rs1={2,1} sop=1 eop=0; cycle+2: pid1 tmask=11 rs1={4,3} sop=0 eop=1; tid=0.
- tmask=4'b1100 -> single packet: pid=1, tmask=11, sop=1, eop=1, tid=2; slice 0 skipped.
- tmask=4'b0000 -> in_ready=1, input consumed, out_valid stays 0 for 3 cycles.
- tmask=1111 with out_ready held low 5 cycles -> pid0 outputs stable and in_ready=0 throughout; after release, pid0 then pid1 emitted.
- Two back-to-back instructions (tmask 1111, then 0011) with out_ready=1 -> out_valid continuous for 3 cycles: (pid0,sop), (pid1,eop), (pid0,sop,eop); meta switches on the third cycle.
- reset asserted while pid0 is pending -> out_valid=0 immediately (asynchronous); after release, no pid1 emitted; in_ready=1.
